// File: rtl/aes_block_engine_if.sv
// Stream bundle for the AES block engine: word input (a), key input (k)
// and block output (d), each with a valid/ready handshake.
// The engine connects through the slave modport; the traffic source uses master.
interface aes_block_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 4
);
  logic                        a_valid;
  logic                        a_ready;
  logic [DATA_WIDTH-1:0]       a_data;
  logic                        k_valid;
  logic                        k_ready;
  logic [DATA_WIDTH-1:0]       k_data;
  logic                        d_valid;
  logic                        d_ready;
  logic [DATA_WIDTH*WORDS-1:0] d_data;

  modport master (
    output a_valid, a_data, k_valid, k_data, d_ready,
    input  a_ready, k_ready, d_valid, d_data
  );

  modport slave (
    input  a_valid, a_data, k_valid, k_data, d_ready,
    output a_ready, k_ready, d_valid, d_data
  );
endinterface

// File: rtl/aes_block_engine.sv
// AES block engine: gathers WORDS stream words into one block, optionally
// XORing each with a lock-step key word, and hands the block downstream.
// A job runs for a programmed number of blocks, then pulses done_o.
module aes_block_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic                 start_i,
  input  logic                 xor_en_i,
  input  logic [CNT_WIDTH-1:0] num_blocks_i,
  aes_block_engine_if.slave    stream,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] blk_cnt_o
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, OUT} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      widx_reg, widx_next;
  logic [CNT_WIDTH-1:0]  num_reg, num_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic                  xor_reg, xor_next;
  logic                  done_reg, done_next;

  logic                  key_ok;
  logic                  accept;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] word_in;
  logic [CNT_WIDTH-1:0]  cnt_inc;

  // In pass mode the key stream plays no part in acceptance.
  assign key_ok    = !xor_reg || stream.k_valid;
  assign accept    = (state_reg == FILL) && enable_i && stream.a_valid && key_ok;
  assign handshake = (state_reg == OUT) && stream.d_ready;
  assign word_in   = xor_reg ? (stream.a_data ^ stream.k_data) : stream.a_data;
  // Cannot wrap inside a job: the job ends when cnt reaches num.
  assign cnt_inc   = cnt_reg + CNT_WIDTH'(1);

  // Ready/valid outputs come from state and the opposite stream's valid only,
  // so no valid ever depends on a ready.
  assign stream.a_ready = (state_reg == FILL) && enable_i && key_ok;
  assign stream.k_ready = (state_reg == FILL) && enable_i && xor_reg && stream.a_valid;
  assign stream.d_valid = (state_reg == OUT);
  assign busy_o         = (state_reg != IDLE);
  assign done_o         = done_reg;
  assign blk_cnt_o      = cnt_reg;

  // One register per word slot; the output block is the slots side by side.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_slot
    logic [DATA_WIDTH-1:0] slot_reg;

    // Capture the accepted word into the slot addressed by the word index.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        slot_reg <= '0;
      end else if (!clear_i && accept && (widx_reg == IDX_W'(gi))) begin
        slot_reg <= word_in;
      end
    end

    assign stream.d_data[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
  end

  // State, index, counters and latched job configuration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      widx_reg  <= '0;
      num_reg   <= '0;
      cnt_reg   <= '0;
      xor_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      widx_reg  <= widx_next;
      num_reg   <= num_next;
      cnt_reg   <= cnt_next;
      xor_reg   <= xor_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic; clear overrides everything decided above it.
  always_comb begin
    state_next = state_reg;
    widx_next  = widx_reg;
    num_next   = num_reg;
    cnt_next   = cnt_reg;
    xor_next   = xor_reg;
    done_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start_i) begin
          num_next  = num_blocks_i;
          xor_next  = xor_en_i;
          cnt_next  = '0;
          widx_next = '0;
          if (num_blocks_i == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          if (widx_reg == LAST_IDX) begin
            widx_next  = '0;
            state_next = OUT;
          end else begin
            widx_next = widx_reg + IDX_W'(1);
          end
        end
      end
      OUT: begin
        if (handshake) begin
          cnt_next = cnt_inc;
          if (cnt_inc == num_reg) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = FILL;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (clear_i) begin
      state_next = IDLE;
      widx_next  = '0;
      cnt_next   = '0;
      done_next  = 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_block_engine.sv
// Bench for aes_block_engine: table of single-block jobs plus hand-written
// sequences for stalls, back-pressure, multi-block jobs, clear/reset and
// ignored starts. Output blocks are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_aes_block_engine;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int CW = 16;
  localparam int BW = DW * NW;

  typedef struct packed {
    logic                 xe;
    logic [NW-1:0][DW-1:0] a;
    logic [NW-1:0][DW-1:0] k;
    logic [BW-1:0]        exp;
  } vec_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clear_i;
  logic          enable_i;
  logic          start_i;
  logic          xor_en_i;
  logic [CW-1:0] num_blocks_i;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] blk_cnt_o;

  aes_block_engine_if #(.DATA_WIDTH(DW), .WORDS(NW)) bus ();

  aes_block_engine #(.DATA_WIDTH(DW), .WORDS(NW), .CNT_WIDTH(CW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .enable_i     (enable_i),
    .start_i      (start_i),
    .xor_en_i     (xor_en_i),
    .num_blocks_i (num_blocks_i),
    .stream       (bus),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .blk_cnt_o    (blk_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int            n_checks = 0;
  int            n_errors = 0;
  int            done_cnt = 0;
  int            k_acc    = 0;
  int            hs_cnt   = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] sb_exp;
  vec_t          vecs[4];

  task automatic chk_d(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Scoreboard / event monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus.d_valid && bus.d_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected got %h want no block", bus.d_data);
        end else begin
          sb_exp = exp_q.pop_front();
          $display("block out data=%h exp=%h", bus.d_data, sb_exp);
          chk_d("sb_block", bus.d_data, sb_exp);
        end
      end
      if (done_o) done_cnt++;
      if (bus.k_valid && bus.k_ready) k_acc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offers one word (and key) until accepted; starts and ends at posedge+1.
  task automatic drive_word(input logic [DW-1:0] a, input logic [DW-1:0] k);
    bit ok;
    ok          = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_data  = a;
    bus.k_valid = 1'b1;
    bus.k_data  = k;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (bus.a_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    if (ok) begin
      @(posedge clk_i);
      #1;
      $display("word accepted a=%h k=%h", a, k);
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL word_timeout got no accept want accept a=%h", a);
    end
    bus.a_valid = 1'b0;
    bus.k_valid = 1'b0;
  endtask

  task automatic send_block(input logic [NW-1:0][DW-1:0] a, input logic [NW-1:0][DW-1:0] k);
    for (int i = 0; i < NW; i++) drive_word(a[i], k[i]);
  endtask

  task automatic start_job(input logic [CW-1:0] num, input logic xe);
    start_i      = 1'b1;
    num_blocks_i = num;
    xor_en_i     = xe;
    step();
    start_i      = 1'b0;
  endtask

  // Waits (bounded) for done_o; ends at posedge+1.
  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    chk_b(name, ok, 1'b1);
    if (ok) step();
  endtask

  task automatic apply_reset();
    rst_i        = 1'b1;
    clear_i      = 1'b0;
    enable_i     = 1'b1;
    start_i      = 1'b0;
    xor_en_i     = 1'b0;
    num_blocks_i = '0;
    bus.a_valid  = 1'b0;
    bus.a_data   = '0;
    bus.k_valid  = 1'b0;
    bus.k_data   = '0;
    bus.d_ready  = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    logic [NW-1:0][DW-1:0] t1a;
    logic [NW-1:0][DW-1:0] ones;
    logic [NW-1:0][DW-1:0] blk;
    logic [BW-1:0]         t1_exp;
    int                    exp_k;
    int                    base;

    t1a    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    ones   = {4{32'hFFFFFFFF}};
    t1_exp = 128'h44444444_33333333_22222222_11111111;

    vecs[0] = '{xe: 1'b0, a: t1a, k: '0, exp: t1_exp};
    vecs[1] = '{xe: 1'b1, a: t1a, k: ones,
                exp: 128'hBBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE};
    vecs[2] = '{xe: 1'b1,
                a: {32'hFFFFFFFF, 32'h12345678, 32'h00000000, 32'hDEADBEEF},
                k: {32'h00000001, 32'h12345678, 32'h0F0F0F0F, 32'hFFFF0000},
                exp: 128'hFFFFFFFE_00000000_0F0F0F0F_2152BEEF};
    vecs[3] = '{xe: 1'b0,
                a: {32'h80000000, 32'h00000001, 32'h5A5A5A5A, 32'hA5A5A5A5},
                k: ones,
                exp: 128'h80000000_00000001_5A5A5A5A_A5A5A5A5};

    // Reset state
    apply_reset();
    @(negedge clk_i);
    chk_b("rst_busy", busy_o, 1'b0);
    chk_b("rst_done", done_o, 1'b0);
    chk_b("rst_dvalid", bus.d_valid, 1'b0);
    chk_d("rst_ddata", bus.d_data, '0);
    chk_d("rst_cnt", BW'(blk_cnt_o), '0);
    bus.a_valid = 1'b1;
    bus.k_valid = 1'b1;
    #1;
    chk_b("rst_aready", bus.a_ready, 1'b0);
    chk_b("rst_kready", bus.k_ready, 1'b0);
    bus.a_valid = 1'b0;
    bus.k_valid = 1'b0;
    step();

    // Table: one-block jobs in both modes
    base  = k_acc;
    exp_k = 0;
    for (int v = 0; v < 4; v++) begin
      exp_k += vecs[v].xe ? NW : 0;
      start_job(1, vecs[v].xe);
      exp_q.push_back(vecs[v].exp);
      send_block(vecs[v].a, vecs[v].k);
      wait_done("vec_done");
      chk_d("vec_cnt", BW'(blk_cnt_o), BW'(1));
      chk_b("vec_busy", busy_o, 1'b0);
    end
    chk_i("vec_key_accepts", k_acc - base, exp_k);

    // T1: latency and done timing
    start_job(1, 1'b0);
    exp_q.push_back(t1_exp);
    send_block(t1a, '0);
    @(negedge clk_i);
    chk_b("t1_dvalid_lat", bus.d_valid, 1'b1);
    chk_d("t1_data", bus.d_data, t1_exp);
    step();
    @(negedge clk_i);
    chk_b("t1_done", done_o, 1'b1);
    chk_d("t1_cnt", BW'(blk_cnt_o), BW'(1));
    step();
    @(negedge clk_i);
    chk_b("t1_done_pulse", done_o, 1'b0);
    step();

    // T2: key stream gap mid-block
    start_job(1, 1'b1);
    exp_q.push_back(~t1_exp);
    drive_word(32'h11111111, 32'hFFFFFFFF);
    drive_word(32'h22222222, 32'hFFFFFFFF);
    bus.a_valid = 1'b1;
    bus.a_data  = 32'h33333333;
    bus.k_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk_b("t2_gap_aready", bus.a_ready, 1'b0);
      chk_b("t2_gap_kready", bus.k_ready, 1'b1);
      step();
    end
    drive_word(32'h33333333, 32'hFFFFFFFF);
    drive_word(32'h44444444, 32'hFFFFFFFF);
    wait_done("t2_done");

    // T3: downstream back-pressure
    blk = {32'h00FF00FF, 32'h55AA55AA, 32'h10203040, 32'h0A0B0C0D};
    start_job(1, 1'b0);
    exp_q.push_back(128'h00FF00FF_55AA55AA_10203040_0A0B0C0D);
    bus.d_ready = 1'b0;
    send_block(blk, '0);
    bus.a_valid = 1'b1;
    bus.a_data  = 32'hDEAD0000;
    base        = hs_cnt;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk_b("t3_dvalid_hold", bus.d_valid, 1'b1);
      chk_d("t3_data_stable", bus.d_data, 128'h00FF00FF_55AA55AA_10203040_0A0B0C0D);
      chk_b("t3_aready", bus.a_ready, 1'b0);
      step();
    end
    bus.d_ready = 1'b1;
    bus.a_valid = 1'b0;
    wait_done("t3_done");
    chk_i("t3_handshakes", hs_cnt - base, 1);

    // T4: zero-block job, then three-block job
    start_job(0, 1'b0);
    @(negedge clk_i);
    chk_b("t4_zero_done", done_o, 1'b1);
    chk_b("t4_zero_busy", busy_o, 1'b0);
    step();
    @(negedge clk_i);
    chk_b("t4_zero_done_pulse", done_o, 1'b0);
    chk_b("t4_zero_busy2", busy_o, 1'b0);
    step();
    base = done_cnt;
    start_job(3, 1'b0);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < NW; i++) blk[i] = 32'h10000000 * (b + 1) + i;
      exp_q.push_back(blk);
      send_block(blk, '0);
      @(negedge clk_i);
      step();
      @(negedge clk_i);
      chk_d("t4_cnt", BW'(blk_cnt_o), BW'(b + 1));
      chk_b("t4_done_at_end", done_o, (b == 2));
      step();
    end
    step();
    chk_i("t4_single_done", done_cnt - base, 1);

    // T5: abort with clear, then with reset; next job restarts at slot 0
    for (int r = 0; r < 2; r++) begin
      start_job(2, 1'b0);
      blk = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
      exp_q.push_back(blk);
      send_block(blk, '0);
      @(negedge clk_i);
      step();
      drive_word(32'hBAD00000, 32'h0);
      drive_word(32'hBAD00001, 32'h0);
      base = done_cnt;
      if (r == 0) clear_i = 1'b1;
      else        rst_i   = 1'b1;
      step();
      clear_i = 1'b0;
      rst_i   = 1'b0;
      @(negedge clk_i);
      chk_b("t5_busy", busy_o, 1'b0);
      chk_b("t5_dvalid", bus.d_valid, 1'b0);
      chk_d("t5_cnt", BW'(blk_cnt_o), '0);
      chk_b("t5_done", done_o, 1'b0);
      step();
      blk = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
      start_job(1, 1'b0);
      exp_q.push_back(blk);
      send_block(blk, '0);
      wait_done("t5_rebuild_done");
      chk_i("t5_done_count", done_cnt - base, 1);
      chk_d("t5_cnt_after", BW'(blk_cnt_o), BW'(1));
    end

    // T6: start ignored in FILL, enable stalls in FILL, enable low in OUT
    start_job(2, 1'b0);
    blk = {32'h60000003, 32'h60000002, 32'h60000001, 32'h60000000};
    exp_q.push_back(blk);
    drive_word(blk[0], 32'hFFFFFFFF);
    start_i      = 1'b1;
    num_blocks_i = '0;
    xor_en_i     = 1'b1;
    step();
    start_i     = 1'b0;
    enable_i    = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_data  = blk[1];
    bus.k_valid = 1'b1;
    bus.k_data  = 32'hFFFFFFFF;
    base        = k_acc;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk_b("t6_en_aready", bus.a_ready, 1'b0);
      chk_b("t6_busy", busy_o, 1'b1);
      step();
    end
    enable_i = 1'b1;
    for (int i = 1; i < NW; i++) drive_word(blk[i], 32'hFFFFFFFF);
    chk_i("t6_no_key_accepts", k_acc - base, 0);
    @(negedge clk_i);
    step();
    blk = {32'h70000003, 32'h70000002, 32'h70000001, 32'h70000000};
    exp_q.push_back(blk);
    send_block(blk, '0);
    enable_i = 1'b0;
    wait_done("t6_done");
    enable_i = 1'b1;
    chk_d("t6_cnt", BW'(blk_cnt_o), BW'(2));
    chk_i("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
